// File: rtl/prewrapper_pkg.sv
// Shared constants for the AXI prewrapper controller and its opcode sequencer:
// controller state codes, opcodes, completion status codes and the sequencer FSM states.
package prewrapper_pkg;

    localparam logic [3:0] CS_IDLE       = 4'd0;
    localparam logic [3:0] CS_INPUT_RDY  = 4'd3;
    localparam logic [3:0] CS_OUTPUT_VAL = 4'd5;
    localparam logic [3:0] CS_SCAN_RD    = 4'd9;

    localparam logic [31:0] OP_NONE  = 32'd0;
    localparam logic [31:0] OP_INPUT = 32'd1;
    localparam logic [31:0] OP_RUN   = 32'd2;
    localparam logic [31:0] OP_ENDR  = 32'd3;
    localparam logic [31:0] OP_TEST  = 32'd4;
    localparam logic [31:0] OP_NEXT  = 32'd5;
    localparam logic [31:0] OP_ENDT  = 32'd6;

    localparam logic [1:0] DS_OK      = 2'd0;
    localparam logic [1:0] DS_TIMEOUT = 2'd1;

    typedef enum logic [3:0] {
        S_IDLE, S_INPUT, S_W_IRDY, S_RUN, S_W_OVAL, S_ENDR,
        S_TEST, S_W_SRD, S_NEXT, S_ENDT, S_W_IDLE, S_DONE
    } seq_state_e;

    // Every state drives one fixed opcode level.
    function automatic logic [31:0] state_opcode(input seq_state_e s);
        case (s)
            S_INPUT: return OP_INPUT;
            S_RUN:   return OP_RUN;
            S_ENDR:  return OP_ENDR;
            S_TEST:  return OP_TEST;
            S_NEXT:  return OP_NEXT;
            S_ENDT:  return OP_ENDT;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/prewrapper_seq_watchdog.sv
// Wait-state watchdog: counts enabled cycles, clears on request, flags the last allowed cycle.
module seq_watchdog #(
    parameter int unsigned P_LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = (P_LIMIT > 2) ? $clog2(P_LIMIT) : 1;

    logic [CW-1:0] cnt_q;

    assign expired_o = en_i && (cnt_q == CW'(P_LIMIT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/prewrapper_seq.sv
// Autonomous INPUT/RUN/ENDR and INPUT/TEST/NEXT.../ENDT opcode sequencer for the prewrapper controller.
// Define SEQ_TIMEOUT_EN to add the wait-state watchdog (and the P_TIMEOUT parameter).
module prewrapper_seq
    import prewrapper_pkg::*;
#(
    parameter int unsigned P_TICK_W = 16
`ifdef SEQ_TIMEOUT_EN
   ,parameter int unsigned P_TIMEOUT = 1024
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_val,
    output logic                cmd_rdy,
    input  logic                cmd_mode,
    input  logic [P_TICK_W-1:0] cmd_ticks,
    output logic [31:0]         seq_opcode,
    input  logic [31:0]         ctrl_state,
    output logic                done_val,
    input  logic                done_ack,
    output logic [1:0]          done_status,
    output logic [P_TICK_W-1:0] tick_cnt,
    output logic                busy,
    output seq_state_e          dbg_state
);
    seq_state_e          state_q, state_d;
    logic                mode_q, mode_d;
    logic [P_TICK_W-1:0] ticks_q, ticks_d;
    logic [P_TICK_W-1:0] tick_q, tick_d;
    logic [31:0]         opcode_q;
    logic                cmd_rdy_q, done_val_q, busy_q;
    logic [3:0]          cs;
    logic [27:0]         unused_ctrl_hi;

    assign cs             = ctrl_state[3:0];
    assign unused_ctrl_hi = ctrl_state[31:4];

`ifdef SEQ_TIMEOUT_EN
    logic       wd_expired;
    logic [1:0] status_q, status_d;

    seq_watchdog #(.P_LIMIT(P_TIMEOUT)) u_watchdog (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (state_d != state_q),
        .en_i      (state_q != S_IDLE && state_q != S_DONE),
        .expired_o (wd_expired)
    );

    // Status is captured on entry to S_DONE and held until the host acknowledges.
    always_comb begin
        status_d = status_q;
        if (state_d != S_DONE)      status_d = DS_OK;
        else if (state_q != S_DONE) status_d = wd_expired ? DS_TIMEOUT : DS_OK;
    end

    assign done_status = status_q;
`else
    assign done_status = DS_OK;
`endif

    // Each opcode is held until the controller leaves the state it asked for.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ticks_d = ticks_q;
        tick_d  = tick_q;
        case (state_q)
            S_IDLE: if (cmd_val && cmd_rdy_q) begin
                mode_d  = cmd_mode;
                ticks_d = cmd_ticks;
                tick_d  = '0;
                state_d = S_INPUT;
            end
            S_INPUT:  if (cs != CS_IDLE)       state_d = S_W_IRDY;
            S_W_IRDY: if (cs == CS_INPUT_RDY)  state_d = mode_q ? S_TEST : S_RUN;
            S_RUN:    if (cs != CS_INPUT_RDY)  state_d = S_W_OVAL;
            S_W_OVAL: if (cs == CS_OUTPUT_VAL) state_d = S_ENDR;
            S_ENDR:   if (cs != CS_OUTPUT_VAL) state_d = S_W_IDLE;
            S_TEST:   if (cs != CS_INPUT_RDY)  state_d = S_W_SRD;
            S_W_SRD:  if (cs == CS_SCAN_RD)    state_d = (tick_q == ticks_q) ? S_ENDT : S_NEXT;
            S_NEXT: if (cs != CS_SCAN_RD) begin
                tick_d  = tick_q + P_TICK_W'(1);
                state_d = S_W_SRD;
            end
            S_ENDT:   if (cs != CS_SCAN_RD)    state_d = S_W_IDLE;
            S_W_IDLE: if (cs == CS_IDLE)       state_d = S_DONE;
            S_DONE:   if (done_ack)            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
`ifdef SEQ_TIMEOUT_EN
        if (wd_expired) begin
            state_d = S_DONE;
            tick_d  = tick_q;
        end
`endif
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            ticks_q    <= '0;
            tick_q     <= '0;
            opcode_q   <= OP_NONE;
            cmd_rdy_q  <= 1'b1;
            done_val_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            status_q   <= DS_OK;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ticks_q    <= ticks_d;
            tick_q     <= tick_d;
            opcode_q   <= state_opcode(state_d);
            cmd_rdy_q  <= (state_d == S_IDLE);
            done_val_q <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
`ifdef SEQ_TIMEOUT_EN
            status_q   <= status_d;
`endif
        end
    end

    assign cmd_rdy    = cmd_rdy_q;
    assign seq_opcode = opcode_q;
    assign done_val   = done_val_q;
    assign tick_cnt   = tick_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule
